// File: rtl/mem_port_arbiter_pkg.sv
// Shared core definitions: bus widths, arbiter owner and state encodings.
// Pure declarations, no logic and no latency.
// No flow control lives here.
package riscv_defines;

    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_DATA_WIDTH = 32;

    // Byte enables presented for an instruction fetch (always a full word).
    localparam logic [3:0] BE_FULL_WORD = 4'hF;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_LSU = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE        = 2'd0,
        ARB_WAIT_GNT    = 2'd1,
        ARB_WAIT_RVALID = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF, LSU and memory-side handshake signals around the arbiter.
// Wires only, no latency.
// req/gnt handshakes, responses are single-cycle rvalid pulses.
interface mem_port_arbiter_if
    import riscv_defines::*;
#(
    parameter int ADDR_W = RISCV_ADDR_WIDTH,
    parameter int DATA_W = RISCV_DATA_WIDTH
) ();

    // Instruction-fetch port
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;

    // Load/store port
    logic              lsu_req_i;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic              lsu_we_i;
    logic [3:0]        lsu_be_i;
    logic [DATA_W-1:0] lsu_wdata_i;
    logic              lsu_gnt_o;
    logic              lsu_rvalid_o;

    // Shared response
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;

    // Memory side
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_err_i;

    // Arbiter view
    modport master (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o,
        input  lsu_req_i, lsu_addr_i, lsu_we_i, lsu_be_i, lsu_wdata_i,
        output lsu_gnt_o, lsu_rvalid_o,
        output rdata_o, err_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );

    // Surrounding core + memory view
    modport slave (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o,
        output lsu_req_i, lsu_addr_i, lsu_we_i, lsu_be_i, lsu_wdata_i,
        input  lsu_gnt_o, lsu_rvalid_o,
        input  rdata_o, err_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );

endinterface

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Response watchdog: counts cycles spent waiting for a memory response.
// expired is a registered-count compare, valid in the same cycle as the count.
// No backpressure; clear has priority over enable, count saturates at expiry.
module arb_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    assign expired = (count == 8'(TIMEOUT - 1));

    // Count waiting cycles; hold once expired so the count never wraps.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 8'd0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between IF and LSU, one transaction in flight, round-robin on ties.
// Grant is combinational from mem_gnt_i (0 cycles); response is forwarded in the rvalid cycle.
// Requesters stall until granted; a lost response becomes an error after TIMEOUT cycles.
module mem_port_arbiter
    import riscv_defines::*;
#(
    parameter int ADDR_W  = RISCV_ADDR_WIDTH,
    parameter int DATA_W  = RISCV_DATA_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.master   bus
);

    arb_state_e state, state_nxt;
    owner_e     owner, owner_nxt;
    owner_e     last_owner, last_owner_nxt;

    // Decoded actions for the current cycle
    logic              do_req;
    owner_e            req_owner;
    logic              do_gnt;
    logic              do_rsp;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;
    owner_e            sel;

    logic              cnt_clear;
    logic              cnt_enable;
    logic              cnt_expired;

    logic [ADDR_W-1:0] req_addr;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    // The counter restarts from zero on every entry into WAIT_RVALID.
    assign cnt_clear  = (state != ARB_WAIT_RVALID);
    assign cnt_enable = (state == ARB_WAIT_RVALID);

    // State, current owner and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= OWNER_IF;
            last_owner <= OWNER_IF;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // Next-state and action decode; reset forces the idle/no-request decode.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        do_req         = 1'b0;
        req_owner      = owner;
        do_gnt         = 1'b0;
        do_rsp         = 1'b0;
        rsp_err        = 1'b0;
        rsp_data       = '0;
        sel            = OWNER_IF;

        if (!rst) begin
            unique case (state)
                ARB_IDLE: begin
                    // On a tie favour whichever port did not win last time.
                    if (bus.if_req_i && bus.lsu_req_i) begin
                        sel = (last_owner == OWNER_IF) ? OWNER_LSU : OWNER_IF;
                    end else if (bus.lsu_req_i) begin
                        sel = OWNER_LSU;
                    end else begin
                        sel = OWNER_IF;
                    end

                    if (bus.if_req_i || bus.lsu_req_i) begin
                        do_req    = 1'b1;
                        req_owner = sel;
                        owner_nxt = sel;
                        if (bus.mem_gnt_i) begin
                            do_gnt         = 1'b1;
                            last_owner_nxt = sel;
                            state_nxt      = ARB_WAIT_RVALID;
                        end else begin
                            state_nxt = ARB_WAIT_GNT;
                        end
                    end
                end

                ARB_WAIT_GNT: begin
                    // Owner is locked in; the request stays up even if the owner withdraws.
                    do_req    = 1'b1;
                    req_owner = owner;
                    if (bus.mem_gnt_i) begin
                        do_gnt         = 1'b1;
                        last_owner_nxt = owner;
                        state_nxt      = ARB_WAIT_RVALID;
                    end
                end

                ARB_WAIT_RVALID: begin
                    // A real response beats the watchdog when both land together.
                    if (bus.mem_rvalid_i) begin
                        do_rsp    = 1'b1;
                        rsp_err   = bus.mem_err_i;
                        rsp_data  = bus.mem_rdata_i;
                        state_nxt = ARB_IDLE;
                    end else if (cnt_expired) begin
                        do_rsp    = 1'b1;
                        rsp_err   = 1'b1;
                        state_nxt = ARB_IDLE;
                    end
                end

                default: begin
                    state_nxt = ARB_IDLE;
                end
            endcase
        end
    end

    assign req_addr = (req_owner == OWNER_LSU) ? bus.lsu_addr_i : bus.if_addr_i;

    // Drive port and memory outputs from the decoded actions; payload is zero when idle.
    always_comb begin
        bus.mem_req_o    = do_req;
        bus.mem_addr_o   = '0;
        bus.mem_we_o     = 1'b0;
        bus.mem_be_o     = 4'h0;
        bus.mem_wdata_o  = '0;
        bus.if_gnt_o     = do_gnt && (req_owner == OWNER_IF);
        bus.lsu_gnt_o    = do_gnt && (req_owner == OWNER_LSU);
        bus.if_rvalid_o  = do_rsp && (owner == OWNER_IF);
        bus.lsu_rvalid_o = do_rsp && (owner == OWNER_LSU);
        bus.rdata_o      = rsp_data;
        bus.err_o        = rsp_err;

        if (do_req) begin
            bus.mem_addr_o = req_addr;
            if (req_owner == OWNER_LSU) begin
                bus.mem_we_o    = bus.lsu_we_i;
                bus.mem_be_o    = bus.lsu_be_i;
                bus.mem_wdata_o = bus.lsu_wdata_i;
            end else begin
                bus.mem_be_o    = BE_FULL_WORD;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random transactions.
// Expectations come from a transaction-level model (winner, grant cycle, response cycle).
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    bit   last_win;   // 0 = IF won the most recent grant, 1 = LSU

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check every output; payload is compared when a request is expected, or zero when pay0 is set.
    task automatic check_all(input string ph, input bit e_req, input logic [31:0] e_addr,
                             input bit e_we, input logic [3:0] e_be, input logic [31:0] e_wd,
                             input bit e_ig, input bit e_lg, input bit e_ir, input bit e_lr,
                             input logic [31:0] e_rd, input bit e_err, input bit pay0);
        chk({ph, ".mem_req"}, b.mem_req_o, e_req);
        if (e_req || pay0) begin
            chk({ph, ".mem_addr"}, b.mem_addr_o, e_req ? e_addr : 32'h0);
            chk({ph, ".mem_we"}, b.mem_we_o, e_req ? e_we : 1'b0);
            chk({ph, ".mem_be"}, b.mem_be_o, e_req ? e_be : 4'h0);
            chk({ph, ".mem_wdata"}, b.mem_wdata_o, e_req ? e_wd : 32'h0);
        end
        chk({ph, ".if_gnt"}, b.if_gnt_o, e_ig);
        chk({ph, ".lsu_gnt"}, b.lsu_gnt_o, e_lg);
        chk({ph, ".if_rvalid"}, b.if_rvalid_o, e_ir);
        chk({ph, ".lsu_rvalid"}, b.lsu_rvalid_o, e_lr);
        chk({ph, ".rdata"}, b.rdata_o, e_rd);
        chk({ph, ".err"}, b.err_o, e_err);
    endtask

    task automatic idle_inputs();
        b.if_req_i     = 1'b0;
        b.lsu_req_i    = 1'b0;
        b.mem_gnt_i    = 1'b0;
        b.mem_rvalid_i = 1'b0;
        b.mem_rdata_i  = 32'h0;
        b.mem_err_i    = 1'b0;
    endtask

    // One transaction. gd: cycles before mem_gnt_i (0 = same cycle as request).
    // rd: cycles from grant cycle to mem_rvalid_i. keep: loser keeps requesting throughout.
    task automatic txn(input string tag, input bit ir, input bit lr,
                       input logic [31:0] ia, input logic [31:0] la, input bit we,
                       input logic [3:0] be, input logic [31:0] wd, input int gd,
                       input int rd, input bit merr, input logic [31:0] rdat, input bit keep);
        bit          win;
        logic [31:0] ea, ewd;
        logic [3:0]  ebe;
        bit          ewe, real_rsp, erv;
        int          dend, last;

        win = (ir && lr) ? !last_win : lr;
        ea  = win ? la : ia;
        ewe = win ? we : 1'b0;
        ebe = win ? be : 4'hF;
        ewd = win ? wd : 32'h0;

        for (int c = 0; c <= gd; c++) begin
            @(negedge clk);
            b.if_req_i     = ir;
            b.lsu_req_i    = lr;
            b.if_addr_i    = ia;
            b.lsu_addr_i   = la;
            b.lsu_we_i     = we;
            b.lsu_be_i     = be;
            b.lsu_wdata_i  = wd;
            b.mem_gnt_i    = (c == gd);
            b.mem_rvalid_i = 1'($urandom);   // stray responses must be ignored
            b.mem_rdata_i  = $urandom;
            b.mem_err_i    = 1'($urandom);
            #1;
            check_all({tag, ".gnt"}, 1'b1, ea, ewe, ebe, ewd,
                      (c == gd) && !win, (c == gd) && win, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        last_win = win;

        real_rsp = (rd <= TO);
        dend     = real_rsp ? rd : TO;
        last     = (rd > dend) ? rd : dend;
        for (int d = 1; d <= last; d++) begin
            @(negedge clk);
            b.if_req_i     = keep && win && ir;
            b.lsu_req_i    = keep && !win && lr;
            b.mem_gnt_i    = (d <= dend) ? 1'($urandom) : 1'b0;
            b.mem_rvalid_i = (d == rd);
            b.mem_rdata_i  = (d == rd) ? rdat : $urandom;
            b.mem_err_i    = (d == rd) ? merr : 1'($urandom);
            #1;
            erv = (d == dend);
            check_all({tag, ".rsp"}, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0,
                      erv && !win, erv && win,
                      (erv && real_rsp) ? rdat : 32'h0,
                      erv ? (real_rsp ? merr : 1'b1) : 1'b0, d > dend);
        end
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        last_win = 1'b0;
        b.if_addr_i   = 32'h0;
        b.lsu_addr_i  = 32'h0;
        b.lsu_we_i    = 1'b0;
        b.lsu_be_i    = 4'h0;
        b.lsu_wdata_i = 32'h0;

        // Reset with every input active: outputs must all be zero.
        rst            = 1'b1;
        b.if_req_i     = 1'b1;
        b.lsu_req_i    = 1'b1;
        b.if_addr_i    = 32'h44;
        b.lsu_addr_i   = 32'h88;
        b.mem_gnt_i    = 1'b1;
        b.mem_rvalid_i = 1'b1;
        b.mem_rdata_i  = 32'hFFFF_FFFF;
        b.mem_err_i    = 1'b1;
        @(negedge clk);
        #1;
        check_all("reset", 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        check_all("idle", 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Single IF fetch, same-cycle grant, response two cycles later.
        txn("if_single", 1, 0, 32'h100, 32'h0, 0, 4'h0, 32'h0, 0, 2, 0, 32'hDEADBEEF, 0);

        // Ties: LSU first after reset history, then alternate.
        txn("tie0", 1, 1, 32'h200, 32'h300, 0, 4'hF, 32'h0, 0, 1, 0, 32'h11111111, 0);
        txn("tie1", 1, 1, 32'h204, 32'h304, 1, 4'h1, 32'h5, 0, 1, 0, 32'h22222222, 0);
        txn("tie2", 1, 1, 32'h208, 32'h308, 0, 4'h2, 32'h0, 1, 2, 1, 32'h33333333, 0);
        txn("tie3", 1, 1, 32'h20C, 32'h30C, 1, 4'h4, 32'h7, 0, 3, 0, 32'h44444444, 0);

        // LSU store with a 3-cycle grant delay while IF keeps requesting; IF served afterwards.
        txn("lsu_store", 1, 1, 32'h400, 32'h500, 1, 4'b0011, 32'h1234, 3, 2, 0, 32'h0, 1);
        txn("if_after", 1, 0, 32'h400, 32'h0, 0, 4'h0, 32'h0, 0, 1, 0, 32'hCAFEF00D, 0);

        // Watchdog: no response, then a late rvalid on the following cycle.
        txn("timeout", 1, 0, 32'h600, 32'h0, 0, 4'h0, 32'h0, 0, TO + 1, 0, 32'h5A5A5A5A, 0);
        // Real response on exactly the timeout cycle.
        txn("rsp_at_to", 0, 1, 32'h0, 32'h700, 0, 4'hC, 32'h0, 1, TO, 0, 32'h89ABCDEF, 0);

        // Reset while waiting for a response.
        @(negedge clk);
        b.if_req_i  = 1'b1;
        b.if_addr_i = 32'h800;
        b.mem_gnt_i = 1'b1;
        #1;
        chk("rstmid.if_gnt", b.if_gnt_o, 1'b1);
        @(negedge clk);
        idle_inputs();
        #1;
        check_all("rstmid.wait", 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst            = 1'b1;
        b.mem_rvalid_i = 1'b1;
        b.mem_rdata_i  = 32'h12345678;
        #1;
        check_all("rstmid.rst", 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("rstmid.stray", 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        last_win = 1'b0;
        txn("rstmid.tie", 1, 1, 32'h900, 32'hA00, 1, 4'h8, 32'h99, 0, 1, 0, 32'h77777777, 0);

        // Random transactions against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(1, 3);
            txn("rand", r[0], r[1], $urandom, $urandom, 1'($urandom), 4'($urandom), $urandom,
                $urandom_range(0, 3), $urandom_range(1, TO + 2), 1'($urandom), $urandom, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
